// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the video front end.
// Mode tables describe the standard 640x480@60 and 800x600@60 rasters.
package vga_timing_pkg;

  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam bit          VGA640_H_POL    = 1'b0;
  localparam bit          VGA640_V_POL    = 1'b0;

  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BP     = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BP     = 23;
  localparam bit          SVGA800_H_POL    = 1'b1;
  localparam bit          SVGA800_V_POL    = 1'b1;

  // Counter width for a 0..total-1 range; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with asynchronous reset to a fixed vector.
// Aligns the timing bundle with downstream pixel-pipeline latency.
module vga_delay_line #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing: sync, data-enable, col/row and strobes,
// with an optional uniform output delay for pipeline alignment.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FP     = VGA640_H_FP,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BP     = VGA640_H_BP,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FP     = VGA640_V_FP,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BP     = VGA640_V_BP,
  parameter bit          H_POL    = VGA640_H_POL,
  parameter bit          V_POL    = VGA640_V_POL,
  parameter int unsigned DELAY    = 0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned CW      = cnt_width(H_TOTAL),
  localparam int unsigned RW      = cnt_width(V_TOTAL)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Enable,
  input  logic          i_Restart,
  output logic          o_HSync,
  output logic          o_VSync,
  output logic          o_Active,
  output logic [CW-1:0] o_Col,
  output logic [RW-1:0] o_Row,
  output logic          o_Line_Start,
  output logic          o_Frame_Start
);

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned OW           = 5 + CW + RW;
  localparam logic [OW-1:0] RST_VEC = {~H_POL, ~V_POL, 1'b0, {CW{1'b0}}, {RW{1'b0}}, 2'b00};

  if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1 || DELAY > 15) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] pipe_out;
  logic          h_sync_on, v_sync_on, active, line_start;

  // Raster counters; restart overrides the enable so it works while frozen.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_Restart) begin
      col_d = '0;
      row_d = '0;
    end else if (i_Enable) begin
      if (col_q == CW'(H_TOTAL - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(V_TOTAL - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Decode compares in 32 bits so a sync end equal to the total never aliases.
  assign h_sync_on  = (32'(col_q) >= H_SYNC_START) && (32'(col_q) < H_SYNC_END);
  assign v_sync_on  = (32'(row_q) >= V_SYNC_START) && (32'(row_q) < V_SYNC_END);
  assign active     = (32'(col_q) < H_ACTIVE) && (32'(row_q) < V_ACTIVE);
  assign line_start = (col_q == '0);

  assign out_d = {h_sync_on ? H_POL : ~H_POL,
                  v_sync_on ? V_POL : ~V_POL,
                  active, col_q, row_q,
                  line_start, line_start && (row_q == '0)};

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      out_q <= RST_VEC;
    end else if (i_Enable) begin
      out_q <= out_d;
    end
  end

  if (DELAY == 0) begin : g_no_delay
    assign pipe_out = out_q;
  end else begin : g_delay
    vga_delay_line #(
      .WIDTH   (OW),
      .DEPTH   (DELAY),
      .RST_VAL (RST_VEC)
    ) u_delay (
      .clk_i (i_Clk),
      .rst_i (i_Rst),
      .en_i  (i_Enable),
      .d_i   (out_q),
      .q_o   (pipe_out)
    );
  end

  assign {o_HSync, o_VSync, o_Active, o_Col, o_Row, o_Line_Start, o_Frame_Start} = pipe_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a small 12x7 raster, with a DELAY=3
// twin and an inverted-polarity, zero-front-porch variant on shared stimulus.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic restart = 1'b0;

  always #5 clk = ~clk;

  logic       hs0, vs0, act0, ls0, fs0;
  logic [3:0] col0;
  logic [2:0] row0;
  logic       hs3, vs3, act3, ls3, fs3;
  logic [3:0] col3;
  logic [2:0] row3;
  logic       hsp, vsp, actp, lsp, fsp;
  logic [3:0] colp;
  logic [2:0] rowp;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(1'b0), .V_POL(1'b0), .DELAY(0)) dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Restart(restart),
    .o_HSync(hs0), .o_VSync(vs0), .o_Active(act0), .o_Col(col0), .o_Row(row0),
    .o_Line_Start(ls0), .o_Frame_Start(fs0));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(1'b0), .V_POL(1'b0), .DELAY(3)) dut3 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Restart(restart),
    .o_HSync(hs3), .o_VSync(vs3), .o_Active(act3), .o_Col(col3), .o_Row(row3),
    .o_Line_Start(ls3), .o_Frame_Start(fs3));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(0), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(1'b1), .V_POL(1'b1), .DELAY(0)) dutp (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Restart(restart),
    .o_HSync(hsp), .o_VSync(vsp), .o_Active(actp), .o_Col(colp), .o_Row(rowp),
    .o_Line_Start(lsp), .o_Frame_Start(fsp));

  logic [11:0] v0, v3;
  assign v0 = {hs0, vs0, act0, col0, row0, ls0, fs0};
  assign v3 = {hs3, vs3, act3, col3, row3, ls3, fs3};

  localparam logic [11:0] RST0 = 12'hC00;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bundle for the n-th pixel of the 12x7 raster (active-low syncs).
  function automatic logic [11:0] exp0(input int n);
    int c, r;
    logic hs, vs, act, ls, fs;
    c   = n % 12;
    r   = (n / 12) % 7;
    hs  = !(c >= 9 && c <= 10);
    vs  = (r != 5);
    act = (c < 8) && (r < 4);
    ls  = (c == 0);
    fs  = ls && (r == 0);
    return {hs, vs, act, 4'(c), 3'(r), ls, fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] hist[$];

  initial begin
    int cnt_fs, cnt_ls, cnt_act, cnt_hs_lo, cnt_vs_lo, cnt_hsp_hi, nen;
    bit found;

    // Reset values, including inverted-polarity variant.
    #1 rst = 1'b1;
    #2;
    check("rst_v0", 32'(v0), 32'(RST0));
    check("rst_v3", 32'(v3), 32'(RST0));
    check("rst_hsp", 32'(hsp), 32'(0));
    check("rst_vsp", 32'(vsp), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Free-run two frames.
    cnt_fs = 0; cnt_ls = 0; cnt_act = 0; cnt_hs_lo = 0; cnt_vs_lo = 0; cnt_hsp_hi = 0;
    for (int k = 1; k <= 168; k++) begin
      tick();
      hist.push_back(v0);
      check("run_v0", 32'(v0), 32'(exp0(k - 1)));
      check("dly_v3", 32'(v3), 32'((k <= 3) ? RST0 : hist[k - 4]));
      check("pol_hs", 32'(hsp), 32'(((k - 1) % 11 >= 8) && ((k - 1) % 11 <= 9)));
      check("pol_vs", 32'(vsp), 32'((((k - 1) / 11) % 7) == 5));
      cnt_fs     += int'(fs0);
      cnt_ls     += int'(ls0);
      cnt_act    += int'(act0);
      cnt_hs_lo  += int'(!hs0);
      cnt_vs_lo  += int'(!vs0);
      cnt_hsp_hi += int'(hsp);
    end
    check("fs_count", 32'(cnt_fs), 32'(2));
    check("ls_count", 32'(cnt_ls), 32'(14));
    check("act_count", 32'(cnt_act), 32'(64));
    check("hs_low_count", 32'(cnt_hs_lo), 32'(28));
    check("vs_low_count", 32'(cnt_vs_lo), 32'(24));
    check("hsp_high_count", 32'(cnt_hsp_hi), 32'(30));

    // Asynchronous reset mid-line at col 5, row 2.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (col0 == 4'd5 && row0 == 3'd2) found = 1'b1;
    end
    check("find_c5r2", 32'(found), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_v0", 32'(v0), 32'(RST0));
    check("midrst_v3", 32'(v3), 32'(RST0));
    check("midrst_hsp", 32'(hsp), 32'(0));
    check("midrst_vsp", 32'(vsp), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("postrst_fs", 32'(fs0), 32'(1));
    check("postrst_v0", 32'(v0), 32'(exp0(0)));

    // Enable toggling 1-on/1-off over 168 clocks.
    rst = 1'b1;
    #1;
    @(posedge clk); #1;
    rst = 1'b0;
    hist.delete();
    nen = 0;
    cnt_fs = 0;
    for (int i = 0; i < 168; i++) begin
      en = (i % 2 == 0);
      tick();
      if (en) begin
        nen++;
        hist.push_back(v0);
      end
      check("en_v0", 32'(v0), 32'(exp0(nen - 1)));
      check("en_v3", 32'(v3), 32'((nen <= 3) ? RST0 : hist[nen - 4]));
      cnt_fs += int'(fs0);
    end
    check("en_fs_count", 32'(cnt_fs), 32'(2));
    en = 1'b1;
    tick();
    check("en_wrap_fs", 32'(fs0), 32'(1));
    check("en_wrap_v0", 32'(v0), 32'(exp0(84)));

    // Restart while the counters hold col 7, row 3.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (col0 == 4'd6 && row0 == 3'd3) found = 1'b1;
    end
    check("find_c6r3", 32'(found), 32'(1));
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_edge_v0", 32'(v0), 32'(exp0(3 * 12 + 7)));
    tick();
    check("rs_next_v0", 32'(v0), 32'(exp0(0)));
    check("rs_next_fs", 32'(fs0), 32'(1));
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("rs_after_v0", 32'(v0), 32'(exp0(k)));
    end

    // Restart applied while the enable is low still takes effect.
    en = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_frozen_v0", 32'(v0), 32'(exp0(11)));
    en = 1'b1;
    tick();
    check("rs_frozen_next_v0", 32'(v0), 32'(exp0(0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
